// File: rtl/des_pkg.sv
// DES permutation tables, mode encoding and permutation helpers (FIPS 46-3).
// Tables use 1-based DES numbering: DES bit n lives at vector bit 64-n.
package des_pkg;

    typedef enum logic {
        DES_MODE_IP = 1'b0,
        DES_MODE_FP = 1'b1
    } des_mode_e;

    localparam int unsigned IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int unsigned FP_TABLE [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    // Output DES bit i+1 takes input DES bit IP_TABLE[i].
    function automatic logic [63:0] des_ip(input logic [63:0] blk);
        logic [63:0] res;
        res = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            res[6'(63 - i)] = blk[6'(64 - IP_TABLE[6'(i)])];
        end
        return res;
    endfunction

    function automatic logic [63:0] des_fp(input logic [63:0] blk);
        logic [63:0] res;
        res = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            res[6'(63 - i)] = blk[6'(64 - FP_TABLE[6'(i)])];
        end
        return res;
    endfunction

    function automatic logic [63:0] swap_halves(input logic [63:0] blk);
        return {blk[31:0], blk[63:32]};
    endfunction

endpackage

// File: rtl/des_perm_lane.sv
// One 64-bit lane: IP, or FP with optional L/R half swap in front of it.
module des_perm_lane
    import des_pkg::*;
(
    input  logic        mode,
    input  logic        swap,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    // Select the permutation; swap only applies on the FP path.
    always_comb begin
        dout = des_ip(din);
        if (mode == DES_MODE_FP) begin
            dout = des_fp(swap ? swap_halves(din) : din);
        end
    end

endmodule

// File: rtl/des_perm_pipe.sv
// Pipelined multi-lane DES IP/FP engine with valid/ready flow control,
// tag sideband and a saturating accepted-block counter.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int unsigned LANES       = 1,
    parameter int unsigned PIPE_STAGES = 1,
    parameter int unsigned TAG_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic                  in_swap,
    input  logic [TAG_W-1:0]      in_tag,
    input  logic [64*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic [64*LANES-1:0]   out_data,
    output logic [31:0]           blk_cnt
);

    localparam int unsigned DW = 64 * LANES;

    logic [DW-1:0]    perm_data;
    logic             v1;
    logic [DW-1:0]    d1;
    logic [TAG_W-1:0] t1;
    logic             s1_unload;
    logic             in_hs;
    logic [31:0]      cnt_q;
    logic [32:0]      cnt_sum;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        des_perm_lane u_lane (
            .mode (in_mode),
            .swap (in_swap),
            .din  (in_data[64*k +: 64]),
            .dout (perm_data[64*k +: 64])
        );
    end

    // Stage 1 accepts when empty or when it hands its beat on this cycle.
    assign in_ready = !v1 | s1_unload;
    assign in_hs    = in_valid & in_ready;

    // Stage 1: captures the permuted beat; data/tag only move with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            t1 <= '0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1 <= perm_data;
                t1 <= in_tag;
            end
        end
    end

    if (PIPE_STAGES == 2) begin : g_two
        logic             v2;
        logic [DW-1:0]    d2;
        logic [TAG_W-1:0] t2;
        logic             load2;

        assign load2     = !v2 | out_ready;
        assign s1_unload = v1 & load2;

        // Stage 2: plain register stage, holds while stalled.
        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
                t2 <= '0;
            end else if (load2) begin
                v2 <= v1;
                if (v1) begin
                    d2 <= d1;
                    t2 <= t1;
                end
            end
        end

        assign out_valid = v2;
        assign out_data  = d2;
        assign out_tag   = t2;
    end else begin : g_one
        assign s1_unload = v1 & out_ready;
        assign out_valid = v1;
        assign out_data  = d1;
        assign out_tag   = t1;
    end

    // One spare bit catches the carry so the count can clamp at all-ones.
    assign cnt_sum = {1'b0, cnt_q} + 33'(LANES);

    // Accepted lane-block counter, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (in_hs) begin
            cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
        end
    end

    assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe: single-lane/1-stage and 4-lane/2-stage instances.
module tb_des_perm_pipe;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Instance A: LANES=1, PIPE_STAGES=1
    logic         a_in_valid, a_in_ready, a_in_mode, a_in_swap, a_out_valid, a_out_ready;
    logic [3:0]   a_in_tag, a_out_tag;
    logic [63:0]  a_in_data, a_out_data;
    logic [31:0]  a_blk_cnt;

    // Instance B: LANES=4, PIPE_STAGES=2
    logic         b_in_valid, b_in_ready, b_in_mode, b_in_swap, b_out_valid, b_out_ready;
    logic [3:0]   b_in_tag, b_out_tag;
    logic [255:0] b_in_data, b_out_data;
    logic [31:0]  b_blk_cnt;

    // Hand-computed FIPS 46-3 vector pairs.
    logic [63:0] ip_in  [4] = '{64'h0000000000000001, 64'h8000000000000000, 64'h0000000000000040, 64'h0123456789ABCDEF};
    logic [63:0] ip_out [4] = '{64'h0000008000000000, 64'h0000000001000000, 64'h8000000000000000, 64'hCC00CCFFF0AAF0AA};
    logic [63:0] fp_in  [4] = '{64'hCC00CCFFF0AAF0AA, 64'h0000000001000000, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] fp_out [4] = '{64'h0123456789ABCDEF, 64'h8000000000000000, 64'h0000000000000040, 64'hFFFFFFFFFFFFFFFF};

    logic [255:0] exp_q [$];
    logic [3:0]   tag_q [$];

    des_perm_pipe #(.LANES(1), .PIPE_STAGES(1), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode),
        .in_swap(a_in_swap), .in_tag(a_in_tag), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_tag(a_out_tag), .out_data(a_out_data), .blk_cnt(a_blk_cnt)
    );

    des_perm_pipe #(.LANES(4), .PIPE_STAGES(2), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_swap(b_in_swap), .in_tag(b_in_tag), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_tag(b_out_tag), .out_data(b_out_data), .blk_cnt(b_blk_cnt)
    );

    always #5 clk = ~clk;

    // Beat i: even = IP (swap set but ignored on i%4==2), odd = FP (swapped input on i%4==3).
    task automatic make_beat(input int i, output logic mode, output logic swap,
                             output logic [255:0] din, output logic [255:0] dexp);
        logic [63:0] v;
        mode = i[0];
        swap = (i % 4 == 2) || (i % 4 == 3);
        din  = '0;
        dexp = '0;
        for (int k = 0; k < 4; k++) begin
            if (!mode) begin
                din[64*k +: 64]  = ip_in[(k + i) % 4];
                dexp[64*k +: 64] = ip_out[(k + i) % 4];
            end else begin
                v = fp_in[(k + i) % 4];
                din[64*k +: 64]  = swap ? {v[31:0], v[63:32]} : v;
                dexp[64*k +: 64] = fp_out[(k + i) % 4];
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); tag_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b1; a_in_valid = 1'b1; b_in_valid = 1'b1;
        a_in_data = 64'h0123456789ABCDEF; b_in_data = '1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_blk_cnt !== 32'd0) begin errors++; $display("FAIL rst_a_cnt: got %h expected 0", a_blk_cnt); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready: got %b expected 1", a_in_ready); end
        checks++; if (a_out_data !== 64'd0) begin errors++; $display("FAIL rst_a_data: got %h expected 0", a_out_data); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_blk_cnt !== 32'd0) begin errors++; $display("FAIL rst_b_cnt: got %h expected 0", b_blk_cnt); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready: got %b expected 1", b_in_ready); end
        checks++; if (b_out_data !== 256'd0 || b_out_tag !== 4'd0) begin errors++; $display("FAIL rst_b_data_tag: got %h/%h expected 0/0", b_out_data, b_out_tag); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL rst_no_emit: got %b/%b expected 0/0", a_out_valid, b_out_valid); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ip_vector;
        do_reset();
        a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_swap = 1'b0; a_in_tag = 4'd5; a_in_data = 64'h0123456789ABCDEF;
        b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_swap = 1'b0; b_in_tag = 4'd9;
        b_in_data = {64'h0123456789ABCDEF, 64'h0000000000000040, 64'h8000000000000000, 64'h0000000000000001};
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin errors++; $display("FAIL ip_accept: got %b/%b expected 1/1", a_in_ready, b_in_ready); end
        @(posedge clk); #1 a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL ip_a_latency: got %b expected 1", a_out_valid); end
        checks++; if (a_out_data !== 64'hCC00CCFFF0AAF0AA) begin errors++; $display("FAIL ip_a_data: got %h expected cc00ccfff0aaf0aa", a_out_data); end
        checks++; if (a_out_tag !== 4'd5) begin errors++; $display("FAIL ip_a_tag: got %h expected 5", a_out_tag); end
        checks++; if (a_blk_cnt !== 32'd1) begin errors++; $display("FAIL ip_a_cnt: got %0d expected 1", a_blk_cnt); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL ip_b_early: got %b expected 0", b_out_valid); end
        checks++; if (b_blk_cnt !== 32'd4) begin errors++; $display("FAIL ip_b_cnt: got %0d expected 4", b_blk_cnt); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL ip_a_dup: got %b expected 0", a_out_valid); end
        checks++; if (b_out_valid !== 1'b1) begin errors++; $display("FAIL ip_b_latency: got %b expected 1", b_out_valid); end
        checks++;
        if (b_out_data !== {64'hCC00CCFFF0AAF0AA, 64'h8000000000000000, 64'h0000000001000000, 64'h0000008000000000}) begin
            errors++; $display("FAIL ip_b_data: got %h", b_out_data);
        end
        checks++; if (b_out_tag !== 4'd9) begin errors++; $display("FAIL ip_b_tag: got %h expected 9", b_out_tag); end
        @(posedge clk); #1;
    endtask

    task automatic test_fp_roundtrip;
        logic        m [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic        s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [63:0] d [4] = '{64'hCC00CCFFF0AAF0AA, 64'hF0AAF0AACC00CCFF, 64'h0123456789ABCDEF, 64'h0100000000000000};
        logic [63:0] e [4] = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA, 64'h8000000000000000};
        do_reset();
        a_out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            a_in_valid = (i < 4);
            if (i < 4) begin
                a_in_mode = m[i]; a_in_swap = s[i]; a_in_data = d[i]; a_in_tag = 4'(i + 2);
            end
            @(negedge clk);
            if (i < 4) begin
                checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fp_ready[%0d]: got %b expected 1", i, a_in_ready); end
            end
            if (i > 0) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== e[i-1] || a_out_tag !== 4'(i + 1)) begin
                    errors++; $display("FAIL fp_out[%0d]: got v=%b %h tag %h expected v=1 %h tag %h", i - 1, a_out_valid, a_out_data, a_out_tag, e[i-1], 4'(i + 1));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mixed;
        logic         mode, swap;
        logic [255:0] din, dexp;
        int sent = 0, recv = 0, cyc = 0, first_out = -1, gaps = 0, stalls = 0;
        do_reset();
        b_out_ready = 1'b1;
        while (recv < 8 && cyc < 50) begin
            b_in_valid = (sent < 8);
            if (sent < 8) begin
                make_beat(sent, mode, swap, din, dexp);
                b_in_mode = mode; b_in_swap = swap; b_in_data = din; b_in_tag = 4'(sent);
            end
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                if (first_out < 0) first_out = cyc;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL mix_extra: got tag %h expected none", b_out_tag); end
                else begin
                    if (b_out_data !== exp_q[0] || b_out_tag !== tag_q[0]) begin
                        errors++; $display("FAIL mix_beat: got tag %h data %h expected tag %h data %h", b_out_tag, b_out_data, tag_q[0], exp_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(tag_q.pop_front());
                end
                recv++;
            end else if (recv > 0) gaps++;
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(dexp); tag_q.push_back(4'(sent)); sent++;
            end else if (b_in_valid) stalls++;
            @(posedge clk); #1; cyc++;
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (recv != 8) begin errors++; $display("FAIL mix_count: got %0d expected 8", recv); end
        checks++; if (first_out != 2) begin errors++; $display("FAIL mix_latency: got %0d expected 2", first_out); end
        checks++; if (gaps != 0 || stalls != 0) begin errors++; $display("FAIL mix_bubbles: got %0d/%0d expected 0/0", gaps, stalls); end
        checks++; if (b_blk_cnt !== 32'd32) begin errors++; $display("FAIL mix_cnt: got %0d expected 32", b_blk_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        logic         mode, swap, prev_ok;
        logic [255:0] din, dexp, prev_d;
        logic [3:0]   prev_t;
        int sent = 0, recv = 0, cyc = 0, max_held = 0, blocked = 0;
        do_reset();
        prev_ok = 1'b0; prev_d = '0; prev_t = '0;
        while (recv < 10 && cyc < 80) begin
            b_out_ready = !(cyc < 5 || (cyc >= 9 && cyc < 12));
            b_in_valid = (sent < 10);
            if (sent < 10) begin
                make_beat(sent, mode, swap, din, dexp);
                b_in_mode = mode; b_in_swap = swap; b_in_data = din; b_in_tag = 4'(sent);
            end
            @(negedge clk);
            if (!b_out_ready) begin
                if (exp_q.size() > max_held) max_held = exp_q.size();
                checks++;
                if (b_in_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL bp_ready c%0d: got %b expected %b", cyc, b_in_ready, exp_q.size() < 2); end
                if (!b_in_ready) blocked++;
                if (prev_ok && b_out_valid) begin
                    checks++;
                    if (b_out_data !== prev_d || b_out_tag !== prev_t) begin errors++; $display("FAIL bp_stable c%0d: got tag %h expected tag %h", cyc, b_out_tag, prev_t); end
                end
                prev_ok = b_out_valid; prev_d = b_out_data; prev_t = b_out_tag;
            end else prev_ok = 1'b0;
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got tag %h expected none", b_out_tag); end
                else begin
                    if (b_out_data !== exp_q[0] || b_out_tag !== tag_q[0]) begin
                        errors++; $display("FAIL bp_beat: got tag %h expected tag %h", b_out_tag, tag_q[0]);
                    end
                    void'(exp_q.pop_front()); void'(tag_q.pop_front());
                end
                recv++;
            end
            if (b_in_valid && b_in_ready) begin
                exp_q.push_back(dexp); tag_q.push_back(4'(sent)); sent++;
            end
            @(posedge clk); #1; cyc++;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        checks++; if (recv != 10 || exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: got %0d/%0d expected 10/0", recv, exp_q.size()); end
        checks++; if (max_held != 2 || blocked == 0) begin errors++; $display("FAIL bp_fill: got held %0d blocked %0d expected 2 and >0", max_held, blocked); end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        b_out_ready = 1'b0; b_in_mode = 1'b0; b_in_swap = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b_in_valid = 1'b1; b_in_tag = 4'(i + 3); b_in_data = '1;
            @(negedge clk);
            checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL mid_fill[%0d]: got %b expected 1", i, b_in_ready); end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_blk_cnt !== 32'd0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", b_blk_cnt); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mid_ghost c%0d: got %b expected 0", c, b_out_valid); end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_tag = 4'hA;
        b_in_data = {64'h0123456789ABCDEF, 64'h0000000000000040, 64'h8000000000000000, 64'h0000000000000001};
        @(posedge clk); #1 b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL mid_restart_early: got %b expected 0", b_out_valid); end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_tag !== 4'hA ||
            b_out_data !== {64'hCC00CCFFF0AAF0AA, 64'h8000000000000000, 64'h0000000001000000, 64'h0000008000000000}) begin
            errors++; $display("FAIL mid_restart: got v=%b tag %h data %h", b_out_valid, b_out_tag, b_out_data);
        end
        checks++; if (b_blk_cnt !== 32'd4) begin errors++; $display("FAIL mid_restart_cnt: got %0d expected 4", b_blk_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation;
        logic [31:0] e [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_reset();
        b_out_ready = 1'b1; b_in_mode = 1'b0; b_in_data = '0;
        dut_b.cnt_q = 32'hFFFF_FFFA;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1; b_in_tag = 4'(i);
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (b_blk_cnt !== e[i]) begin errors++; $display("FAIL sat[%0d]: got %h expected %h", i, b_blk_cnt, e[i]); end
        end
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (b_blk_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffffffff", b_blk_cnt); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_swap = 1'b0; a_in_tag = '0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_swap = 1'b0; b_in_tag = '0; b_in_data = '0; b_out_ready = 1'b1;
        test_reset();
        test_ip_vector();
        test_fp_roundtrip();
        test_mixed();
        test_backpressure();
        test_reset_midstream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
